// File: rtl/early_jump_ras_unit.sv
// Early jump unit with speculative and committed return-address stacks.
// Decodes JAL/JALR classes in fetch, redirects fetch early for direct jumps
// and returns, and keeps a speculative RAS that is rebuilt from the
// committed RAS on a pipeline flush.
module early_jump_ras_unit #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned RAS_DEPTH = 4,
    parameter bit          LINK_X5   = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    input  logic            issue_ready_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            btb_hit_i,
    input  logic            btb_taken_i,
    input  logic [XLEN-1:0] btb_target_i,
    input  logic            commit_push_i,
    input  logic            commit_pop_i,
    input  logic [XLEN-1:0] commit_link_i,
    output logic            early_jump_valid_o,
    output logic [XLEN-1:0] early_target_o,
    output logic            mem_flush_o,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t PTR_MAX = ptr_t'(RAS_DEPTH - 1);
    localparam cnt_t CNT_MAX = cnt_t'(RAS_DEPTH);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        C_NONE,
        C_JAL,
        C_CALL,
        C_RET,
        C_CORO,
        C_ICALL
    } jclass_e;

    typedef enum logic {
        S_IDLE,
        S_WAIT_ISSUE
    } state_e;

    // Result of one stack step: new pointer/count and an optional entry write.
    typedef struct packed {
        ptr_t ptr;
        cnt_t cnt;
        logic we;
        ptr_t widx;
    } ras_upd_t;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_MAX) ? '0 : ptr_t'(p + ptr_t'(1));
    endfunction

    function automatic ptr_t ptr_dec(input ptr_t p);
        return (p == '0) ? PTR_MAX : ptr_t'(p - ptr_t'(1));
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (LINK_X5 && (r == 5'd5));
    endfunction

    // ptr is the next free slot; top lives at ptr-1. Pop on empty is a no-op,
    // pop+push rewrites the top in place, push on full overwrites the oldest.
    function automatic ras_upd_t ras_update(input ptr_t ptr, input cnt_t cnt,
                                            input logic push, input logic pop);
        ras_upd_t u;
        logic     pop_ok;
        u.ptr  = ptr;
        u.cnt  = cnt;
        u.we   = 1'b0;
        u.widx = ptr;
        pop_ok = pop && (cnt != '0);
        if (pop_ok && push) begin
            u.we   = 1'b1;
            u.widx = ptr_dec(ptr);
        end else if (pop_ok) begin
            u.ptr = ptr_dec(ptr);
            u.cnt = cnt_t'(cnt - cnt_t'(1));
        end else if (push) begin
            u.we   = 1'b1;
            u.widx = ptr;
            u.ptr  = ptr_inc(ptr);
            u.cnt  = (cnt == CNT_MAX) ? cnt : cnt_t'(cnt + cnt_t'(1));
        end
        return u;
    endfunction

    state_e          state;
    jclass_e         r_cls;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link;

    logic [XLEN-1:0] s_ent [RAS_DEPTH];
    ptr_t            s_ptr;
    cnt_t            s_cnt;
    logic [XLEN-1:0] c_ent [RAS_DEPTH];
    logic [XLEN-1:0] c_ent_n [RAS_DEPTH];
    ptr_t            c_ptr;
    cnt_t            c_cnt;

    ras_upd_t        s_upd;
    ras_upd_t        c_upd;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [2:0]      funct3;
    logic [11:0]     imm_i;
    logic [XLEN-1:0] imm_j;

    jclass_e         dec_cls;
    logic [XLEN-1:0] dec_target;
    logic            dec_tv;
    logic [XLEN-1:0] s_top;
    logic            s_empty;

    logic            in_wait;
    logic            active;
    logic            handshake;
    jclass_e         cur_cls;
    logic [XLEN-1:0] cur_link;
    logic            s_push;
    logic            s_pop;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign imm_i  = instr_i[31:20];
    assign imm_j  = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};

    assign s_top   = s_ent[ptr_dec(s_ptr)];
    assign s_empty = (s_cnt == '0);

    // Classify the fetched instruction into jump classes.
    always_comb begin
        dec_cls = C_NONE;
        if (opcode == OP_JAL) begin
            dec_cls = is_link(rd) ? C_CALL : C_JAL;
        end else if ((opcode == OP_JALR) && (funct3 == 3'b000)) begin
            if ((rd == 5'd0) && is_link(rs1) && (imm_i == '0)) begin
                dec_cls = C_RET;
            end else if (is_link(rd) && is_link(rs1) && (rd != rs1) && (imm_i == '0)) begin
                dec_cls = C_CORO;
            end else if (is_link(rd)) begin
                dec_cls = C_ICALL;
            end
        end
    end

    // Early target and its validity for the live (not yet registered) instruction.
    always_comb begin
        dec_target = '0;
        dec_tv     = 1'b0;
        case (dec_cls)
            C_JAL, C_CALL: begin
                dec_target = pc_i + imm_j;
                dec_tv     = !btb_hit_i;
            end
            C_RET, C_CORO: begin
                dec_target = s_top;
                dec_tv     = !s_empty;
            end
            default: begin
                dec_target = '0;
                dec_tv     = 1'b0;
            end
        endcase
    end

    assign in_wait   = (state == S_WAIT_ISSUE);
    assign active    = rst_ni && !flush_i;
    assign handshake = instr_valid_i && issue_ready_i;
    assign cur_cls   = in_wait ? r_cls  : dec_cls;
    assign cur_link  = in_wait ? r_link : pc_i + XLEN'(4);

    assign s_push = handshake && ((cur_cls == C_CALL) || (cur_cls == C_ICALL) ||
                                  (cur_cls == C_CORO));
    assign s_pop  = handshake && ((cur_cls == C_RET) || (cur_cls == C_CORO));

    assign s_upd = ras_update(s_ptr, s_cnt, s_push, s_pop);
    assign c_upd = ras_update(c_ptr, c_cnt, commit_push_i, commit_pop_i);

    // Committed stack contents after this cycle's commit, also the flush source.
    always_comb begin
        c_ent_n = c_ent;
        if (c_upd.we) begin
            c_ent_n[c_upd.widx] = commit_link_i;
        end
    end

    // Redirect and prediction outputs; a stalled jump replays its registered target.
    always_comb begin
        early_jump_valid_o = active && (in_wait || (instr_valid_i && dec_tv));
        early_target_o     = '0;
        if (active) begin
            early_target_o = in_wait ? r_target : dec_target;
        end
        mem_flush_o   = early_jump_valid_o && issue_ready_i;
        pred_hit_o    = early_jump_valid_o || btb_hit_i;
        pred_taken_o  = early_jump_valid_o || btb_taken_i;
        pred_target_o = early_jump_valid_o ? early_target_o : btb_target_i;
    end

    assign ras_empty_o = s_empty;
    assign ras_full_o  = (s_cnt == CNT_MAX);

    // Hold the early jump across issue back-pressure so fetch keeps the redirect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            r_cls    <= C_NONE;
            r_target <= '0;
            r_link   <= '0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid_i && dec_tv && !issue_ready_i) begin
                        state    <= S_WAIT_ISSUE;
                        r_cls    <= dec_cls;
                        r_target <= dec_target;
                        r_link   <= pc_i + XLEN'(4);
                    end
                end
                S_WAIT_ISSUE: begin
                    if (issue_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Update committed stack; speculative stack follows handshakes or is rebuilt on flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_ptr <= '0;
            s_cnt <= '0;
            c_ptr <= '0;
            c_cnt <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                s_ent[i] <= '0;
                c_ent[i] <= '0;
            end
        end else begin
            c_ent <= c_ent_n;
            c_ptr <= c_upd.ptr;
            c_cnt <= c_upd.cnt;
            if (flush_i) begin
                s_ent <= c_ent_n;
                s_ptr <= c_upd.ptr;
                s_cnt <= c_upd.cnt;
            end else begin
                if (s_upd.we) begin
                    s_ent[s_upd.widx] <= cur_link;
                end
                s_ptr <= s_upd.ptr;
                s_cnt <= s_upd.cnt;
            end
        end
    end

endmodule

// File: tb/tb_early_jump_ras_unit.sv
// Randomized and directed bench for early_jump_ras_unit against a queue-based
// reference model of the speculative and committed return-address stacks.
module tb_early_jump_ras_unit;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;

    localparam int K_NONE  = 0;
    localparam int K_JAL   = 1;
    localparam int K_CALL  = 2;
    localparam int K_RET   = 3;
    localparam int K_CORO  = 4;
    localparam int K_ICALL = 5;

    logic            clk;
    logic            rst_ni;
    logic            flush_i;
    logic [31:0]     instr_i;
    logic            instr_valid_i;
    logic            issue_ready_i;
    logic [XLEN-1:0] pc_i;
    logic            btb_hit_i;
    logic            btb_taken_i;
    logic [XLEN-1:0] btb_target_i;
    logic            commit_push_i;
    logic            commit_pop_i;
    logic [XLEN-1:0] commit_link_i;
    logic            early_jump_valid_o;
    logic [XLEN-1:0] early_target_o;
    logic            mem_flush_o;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            ras_empty_o;
    logic            ras_full_o;

    early_jump_ras_unit #(
        .XLEN     (XLEN),
        .RAS_DEPTH(DEPTH),
        .LINK_X5  (1'b1)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .instr_i           (instr_i),
        .instr_valid_i     (instr_valid_i),
        .issue_ready_i     (issue_ready_i),
        .pc_i              (pc_i),
        .btb_hit_i         (btb_hit_i),
        .btb_taken_i       (btb_taken_i),
        .btb_target_i      (btb_target_i),
        .commit_push_i     (commit_push_i),
        .commit_pop_i      (commit_pop_i),
        .commit_link_i     (commit_link_i),
        .early_jump_valid_o(early_jump_valid_o),
        .early_target_o    (early_target_o),
        .mem_flush_o       (mem_flush_o),
        .pred_hit_o        (pred_hit_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .ras_empty_o       (ras_empty_o),
        .ras_full_o        (ras_full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stacks as queues, back = top.
    logic [63:0] sq[$];
    logic [63:0] cq[$];
    bit          model_ok = 0;
    bit          held = 0;
    int          h_kind;
    logic [63:0] h_tgt;
    logic [63:0] h_link;
    // Per-cycle values computed before the edge, consumed at the edge.
    bit          e_ev;
    bit          e_tv;
    logic [63:0] e_tgt;
    int          ckind;
    logic [63:0] clink;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit islink(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic int classify(input logic [31:0] ins);
        logic [4:0] rd;
        logic [4:0] rs;
        rd = ins[11:7];
        rs = ins[19:15];
        if (ins[6:0] == 7'h6f) return islink(rd) ? K_CALL : K_JAL;
        if (ins[6:0] == 7'h67 && ins[14:12] == 3'd0) begin
            if (rd == 5'd0 && islink(rs) && ins[31:20] == 12'd0) return K_RET;
            if (islink(rd) && islink(rs) && rd != rs && ins[31:20] == 12'd0) return K_CORO;
            if (islink(rd)) return K_ICALL;
        end
        return K_NONE;
    endfunction

    function automatic logic [63:0] jal_off(input logic [31:0] ins);
        logic [20:0] o;
        o = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return {{43{o[20]}}, o};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            3:       return 5'd2;
            default: return 5'($urandom_range(6, 31));
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [20:0] ji;
        ji = 21'($urandom);
        case ($urandom_range(0, 5))
            0:       return enc_jal(rreg(), ji);
            1:       return enc_jalr(5'd0, ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5, 12'd0);
            2:       return ($urandom_range(0, 1) != 0) ? enc_jalr(5'd1, 5'd5, 12'd0)
                                                        : enc_jalr(5'd5, 5'd1, 12'd0);
            3:       return enc_jalr(rreg(), rreg(),
                                     ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'd0);
            4:       return enc_jal(5'd1, ji);
            default: return $urandom;
        endcase
    endfunction

    // Compute expectations for the current inputs and compare outputs.
    task automatic settle_check();
        #1;
        ckind = held ? h_kind : classify(instr_i);
        clink = held ? h_link : pc_i + 64'd4;
        e_tv  = 0;
        e_tgt = '0;
        if (ckind == K_JAL || ckind == K_CALL) begin
            e_tv  = !btb_hit_i;
            e_tgt = pc_i + jal_off(instr_i);
        end else if (ckind == K_RET || ckind == K_CORO) begin
            e_tv  = (sq.size() > 0);
            e_tgt = (sq.size() > 0) ? sq[sq.size()-1] : 64'd0;
        end
        if (held) e_tgt = h_tgt;
        if (!rst_ni || flush_i) e_ev = 0;
        else if (held)          e_ev = 1;
        else                    e_ev = instr_valid_i && e_tv;
        check("ejv", early_jump_valid_o, e_ev);
        check("mflush", mem_flush_o, e_ev && issue_ready_i);
        if (e_ev) check("etgt", early_target_o, e_tgt);
        check("phit", pred_hit_o, e_ev || btb_hit_i);
        check("ptaken", pred_taken_o, e_ev || btb_taken_i);
        check("ptgt", pred_target_o, e_ev ? e_tgt : btb_target_i);
        if (model_ok) begin
            check("empty", ras_empty_o, sq.size() == 0);
            check("full", ras_full_o, sq.size() == DEPTH);
        end
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic clock_adv();
        @(posedge clk);
        if (!rst_ni) begin
            sq.delete();
            cq.delete();
            held     = 0;
            model_ok = 1;
        end else begin
            if (commit_pop_i && cq.size() > 0) void'(cq.pop_back());
            if (commit_push_i) begin
                cq.push_back(commit_link_i);
                if (cq.size() > DEPTH) void'(cq.pop_front());
            end
            if (flush_i) begin
                sq   = cq;
                held = 0;
            end else begin
                if (instr_valid_i && issue_ready_i) begin
                    if ((ckind == K_RET || ckind == K_CORO) && sq.size() > 0) void'(sq.pop_back());
                    if (ckind == K_CALL || ckind == K_ICALL || ckind == K_CORO) begin
                        sq.push_back(clink);
                        if (sq.size() > DEPTH) void'(sq.pop_front());
                    end
                end
                if (held) begin
                    if (issue_ready_i) held = 0;
                end else if (instr_valid_i && e_tv && !issue_ready_i) begin
                    held   = 1;
                    h_kind = ckind;
                    h_tgt  = e_tgt;
                    h_link = pc_i + 64'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic setin(input logic v, input logic rdy, input logic [63:0] pc,
                         input logic [31:0] ins);
        instr_valid_i = v;
        issue_ready_i = rdy;
        pc_i          = pc;
        instr_i       = ins;
        flush_i       = 1'b0;
        btb_hit_i     = 1'b0;
        btb_taken_i   = 1'b0;
        btb_target_i  = 64'hDEAD_0000;
        commit_push_i = 1'b0;
        commit_pop_i  = 1'b0;
        commit_link_i = '0;
        rst_ni        = 1'b1;
    endtask

    initial begin
        // Reset with busy inputs: nothing may leak out.
        setin(1'b1, 1'b1, 64'h1000, enc_jal(5'd1, 21'h100));
        rst_ni        = 1'b0;
        flush_i       = 1'b1;
        commit_push_i = 1'b1;
        commit_link_i = 64'h55;
        for (int i = 0; i < 2; i++) begin
            settle_check();
            check("rst_ejv", early_jump_valid_o, 1'b0);
            check("rst_mf", mem_flush_o, 1'b0);
            clock_adv();
        end
        setin(1'b0, 1'b1, 64'h0, 32'h13);
        settle_check();
        check("rst_empty", ras_empty_o, 1'b1);
        check("rst_full", ras_full_o, 1'b0);
        clock_adv();

        // JAL x1 +0x100 at 0x1000, then RET observes pushed link.
        setin(1'b1, 1'b1, 64'h1000, enc_jal(5'd1, 21'h100));
        settle_check();
        check("j_tgt", early_target_o, 64'h1100);
        check("j_v", early_jump_valid_o, 1'b1);
        check("j_mf", mem_flush_o, 1'b1);
        clock_adv();
        setin(1'b1, 1'b1, 64'h5000, enc_jalr(5'd0, 5'd1, 12'd0));
        settle_check();
        check("j_top", early_target_o, 64'h1004);
        clock_adv();

        // CALL at 0x2000 then RET.
        setin(1'b1, 1'b1, 64'h2000, enc_jal(5'd1, 21'h40));
        settle_check();
        clock_adv();
        setin(1'b1, 1'b1, 64'h2100, enc_jalr(5'd0, 5'd1, 12'd0));
        settle_check();
        check("cr_tgt", early_target_o, 64'h2004);
        clock_adv();
        setin(1'b0, 1'b1, 64'h0, 32'h13);
        settle_check();
        check("cr_empty", ras_empty_o, 1'b1);
        clock_adv();

        // Five calls into a four-deep stack, then five returns.
        for (int i = 1; i <= 5; i++) begin
            setin(1'b1, 1'b1, 64'(i) * 64'h100, enc_jal(5'd5, 21'h800));
            settle_check();
            clock_adv();
        end
        setin(1'b0, 1'b1, 64'h0, 32'h13);
        settle_check();
        check("ov_full", ras_full_o, 1'b1);
        clock_adv();
        for (int i = 0; i < 5; i++) begin
            setin(1'b1, 1'b1, 64'h9000, enc_jalr(5'd0, 5'd5, 12'd0));
            settle_check();
            check("ov_v", early_jump_valid_o, i < 4);
            if (i < 4) check("ov_tgt", early_target_o, 64'h504 - 64'(i) * 64'h100);
            clock_adv();
        end

        // Stalled call: held redirect while instr_i changes, single push.
        for (int i = 0; i < 4; i++) begin
            setin(1'b1, i == 3, 64'h6000, (i == 0) ? enc_jal(5'd1, 21'h80) : gen_instr());
            if (i != 0) pc_i = {$urandom, $urandom};
            settle_check();
            check("st_v", early_jump_valid_o, 1'b1);
            check("st_tgt", early_target_o, 64'h6080);
            check("st_mf", mem_flush_o, i == 3);
            clock_adv();
        end
        setin(1'b1, 1'b1, 64'h6100, enc_jalr(5'd0, 5'd1, 12'd0));
        settle_check();
        check("st_ret", early_target_o, 64'h6004);
        clock_adv();
        setin(1'b1, 1'b1, 64'h6200, enc_jalr(5'd0, 5'd1, 12'd0));
        settle_check();
        check("st_once", early_jump_valid_o, 1'b0);
        clock_adv();

        // Two speculative calls, one commit, flush rebuilds from committed.
        setin(1'b1, 1'b1, 64'h7000, enc_jal(5'd1, 21'h10));
        settle_check();
        clock_adv();
        setin(1'b1, 1'b1, 64'h7100, enc_jal(5'd1, 21'h10));
        settle_check();
        clock_adv();
        setin(1'b0, 1'b1, 64'h0, 32'h13);
        commit_push_i = 1'b1;
        commit_link_i = 64'hABC0;
        settle_check();
        clock_adv();
        setin(1'b1, 1'b1, 64'h8000, enc_jal(5'd1, 21'h10));
        flush_i = 1'b1;
        settle_check();
        check("fl_v", early_jump_valid_o, 1'b0);
        check("fl_mf", mem_flush_o, 1'b0);
        clock_adv();
        setin(1'b1, 1'b1, 64'h8100, enc_jalr(5'd0, 5'd1, 12'd0));
        settle_check();
        check("fl_tgt", early_target_o, 64'hABC0);
        clock_adv();
        setin(1'b0, 1'b1, 64'h0, 32'h13);
        commit_pop_i = 1'b1;
        settle_check();
        check("fl_empty", ras_empty_o, 1'b1);
        clock_adv();

        // Coroutine swap replaces the top.
        setin(1'b1, 1'b1, 64'h2FFC, enc_jal(5'd1, 21'h4));
        settle_check();
        clock_adv();
        setin(1'b1, 1'b1, 64'h4000, enc_jalr(5'd1, 5'd5, 12'd0));
        settle_check();
        check("co_tgt", early_target_o, 64'h3000);
        clock_adv();
        setin(1'b1, 1'b1, 64'h4100, enc_jalr(5'd0, 5'd1, 12'd0));
        settle_check();
        check("co_top", early_target_o, 64'h4004);
        clock_adv();
        setin(1'b0, 1'b1, 64'h0, 32'h13);
        settle_check();
        check("co_empty", ras_empty_o, 1'b1);
        clock_adv();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] pc;
            pc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom & 32'hFC);
            setin(held ? 1'b1 : ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0,
                  pc, gen_instr());
            btb_hit_i     = $urandom_range(0, 3) == 0;
            btb_taken_i   = $urandom_range(0, 1) != 0;
            btb_target_i  = {$urandom, $urandom};
            flush_i       = $urandom_range(0, 15) == 0;
            commit_push_i = $urandom_range(0, 5) == 0;
            commit_pop_i  = $urandom_range(0, 5) == 0;
            commit_link_i = {$urandom, $urandom};
            rst_ni        = $urandom_range(0, 499) != 0;
            settle_check();
            clock_adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
